// File: rtl/enc_pkg.sv
// Shared definitions for the streaming extended-Hamming encoder:
// per-word mode enum, N/K/P constants per code size, and the mapping from
// data bit index to Hamming position (skipping powers of two).
package enc_pkg;

  typedef enum logic [1:0] {
    MODE_S   = 2'b00,
    MODE_M   = 2'b01,
    MODE_L   = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  localparam int unsigned N_S = 8;
  localparam int unsigned K_S = 4;
  localparam int unsigned P_S = 4;
  localparam int unsigned N_M = 16;
  localparam int unsigned K_M = 11;
  localparam int unsigned P_M = 5;
  localparam int unsigned N_L = 32;
  localparam int unsigned K_L = 26;
  localparam int unsigned P_L = 6;
  localparam int unsigned K_MAX = K_L;

  function automatic int unsigned mode_n(input mode_e m);
    case (m)
      MODE_S:  return N_S;
      MODE_M:  return N_M;
      MODE_L:  return N_L;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned mode_k(input mode_e m);
    case (m)
      MODE_S:  return K_S;
      MODE_M:  return K_M;
      MODE_L:  return K_L;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned mode_p(input mode_e m);
    case (m)
      MODE_S:  return P_S;
      MODE_M:  return P_M;
      MODE_L:  return P_L;
      default: return 0;
    endcase
  endfunction

  // Position of data bit idx: idx-th position >= 3 that is not a power of two.
  function automatic logic [5:0] data_pos(input int unsigned idx);
    int unsigned cnt;
    logic [5:0]  pos;
    cnt = 0;
    pos = '0;
    for (int unsigned p = 3; p < 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = 6'(p);
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/enc_stream_hamming_if.sv
// Handshake bundle for enc_stream_hamming.
// Input side: in_valid/in_ready, data_in, codeword_width (and err_mask when
// ENC_ERR_INJECT_EN is defined). Output side: out_valid/out_ready, enc_out.
// master = producer/consumer side (bench), slave = encoder.
interface enc_stream_hamming_if #(
  parameter int unsigned AMBA_WORD = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [AMBA_WORD-1:0] data_in;
  logic [1:0]           codeword_width;
  logic                 out_valid;
  logic                 out_ready;
  logic [AMBA_WORD-1:0] enc_out;
`ifdef ENC_ERR_INJECT_EN
  logic [AMBA_WORD-1:0] err_mask;

  modport master (output in_valid, data_in, codeword_width, out_ready, err_mask,
                  input  in_ready, out_valid, enc_out);
  modport slave  (input  in_valid, data_in, codeword_width, out_ready, err_mask,
                  output in_ready, out_valid, enc_out);
`else
  modport master (output in_valid, data_in, codeword_width, out_ready,
                  input  in_ready, out_valid, enc_out);
  modport slave  (input  in_valid, data_in, codeword_width, out_ready,
                  output in_ready, out_valid, enc_out);
`endif
endinterface

// File: rtl/enc_parity_gen.sv
// Combinational extended-Hamming encoder.
// Ports: data (K-bit data right-aligned, upper bits ignored), mode (code size),
// code (codeword {zeros, p[P-1..0], d[K-1..0]}; zero for reserved mode).
import enc_pkg::*;

module enc_parity_gen #(
  parameter int unsigned AMBA_WORD = 32
) (
  input  logic [AMBA_WORD-1:0] data,
  input  mode_e                mode,
  output logic [AMBA_WORD-1:0] code
);

  logic [K_MAX-1:0] d;
  logic [31:0]      cw;
  logic [5:0]       par;
  logic [5:0]       pos;
  logic             ovr;
  int unsigned      k;
  int unsigned      p;
  logic             unused_hi;

  assign unused_hi = ^data[AMBA_WORD-1:K_MAX];

  always_comb begin
    d   = data[K_MAX-1:0];
    k   = mode_k(mode);
    p   = mode_p(mode);
    par = '0;
    pos = '0;
    cw  = '0;
    // p_j covers data bits whose Hamming position has bit j set
    for (int unsigned i = 0; i < K_MAX; i++) begin
      if (i < k && d[5'(i)]) begin
        pos = data_pos(i);
        for (int unsigned j = 0; j < 5; j++) begin
          if (j + 1 < p && pos[3'(j)]) par[3'(j)] = ~par[3'(j)];
        end
      end
    end
    // overall parity over data and the lower parity bits
    ovr = ^par;
    for (int unsigned i = 0; i < K_MAX; i++) begin
      if (i < k) begin
        ovr          = ovr ^ d[5'(i)];
        cw[5'(i)]    = d[5'(i)];
      end
    end
    for (int unsigned j = 0; j < 6; j++) begin
      if (j + 1 == p) par[3'(j)] = ovr;
    end
    for (int unsigned j = 0; j < 6; j++) begin
      if (j < p) cw[5'(k + j)] = par[3'(j)];
    end
    code = AMBA_WORD'(cw);
  end

endmodule

// File: rtl/enc_stream_hamming.sv
// Streaming extended-Hamming encoder: S1 (masked data + mode) -> S2
// (codeword) -> output FIFO, all stages backpressured.
// Ports: clk, rst (sync, active-high), bus (enc_stream_hamming_if.slave),
// enc_count (saturating FIFO-write count), mode_err (sticky reserved-mode flag).
// Optional: ENC_ERR_INJECT_EN adds bus.err_mask, XORed into the codeword.
import enc_pkg::*;

module enc_stream_hamming #(
  parameter int unsigned AMBA_WORD  = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  enc_stream_hamming_if.slave  bus,
  output logic [CNT_WIDTH-1:0] enc_count,
  output logic                 mode_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  function automatic logic [AMBA_WORD-1:0] low_mask(input int unsigned n);
    return AMBA_WORD'((64'(1) << n) - 64'(1));
  endfunction

  logic                 s1_valid;
  logic [AMBA_WORD-1:0] s1_data;
  mode_e                s1_mode;
  logic [AMBA_WORD-1:0] s1_code;
  logic [AMBA_WORD-1:0] s2_in;
  logic                 s2_valid;
  logic [AMBA_WORD-1:0] s2_code;
  logic [AMBA_WORD-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        fill;
  logic [AW-1:0]        rd_next;
  logic [AMBA_WORD-1:0] head_q;
  logic                 fifo_empty, fifo_full, fifo_rd, fifo_wr;
  logic                 s2_free, s1_rsv, s1_adv, s1_free;
  logic                 in_rdy, in_fire;
  mode_e                in_mode;

  // Stage chain: each stage may advance when the next one is empty or advancing
  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == PW'(FIFO_DEPTH));
  assign fifo_rd    = !fifo_empty && bus.out_ready;
  assign fifo_wr    = s2_valid && (!fifo_full || fifo_rd);
  assign s2_free    = !s2_valid || fifo_wr;
  assign s1_rsv     = (s1_mode == MODE_RSV);
  assign s1_adv     = s1_valid && (s1_rsv || s2_free);
  assign s1_free    = !s1_valid || s1_adv;
  assign in_rdy     = !rst && s1_free;
  assign in_fire    = bus.in_valid && in_rdy;
  assign in_mode    = mode_e'(bus.codeword_width);
  assign rd_next    = AW'(rd_ptr[AW-1:0] + AW'(1));

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = !fifo_empty;
  assign bus.enc_out   = head_q;

  enc_parity_gen #(.AMBA_WORD(AMBA_WORD)) u_parity (
    .data (s1_data),
    .mode (s1_mode),
    .code (s1_code)
  );

`ifdef ENC_ERR_INJECT_EN
  logic [AMBA_WORD-1:0] s1_mask;

  always_ff @(posedge clk) begin
    if (rst)          s1_mask <= '0;
    else if (in_fire) s1_mask <= bus.err_mask & low_mask(mode_n(in_mode));
  end

  assign s2_in = s1_code ^ s1_mask;
`else
  assign s2_in = s1_code;
`endif

  // Pipeline, pointers, head register and status
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_mode   <= MODE_S;
      s2_valid  <= 1'b0;
      s2_code   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      head_q    <= '0;
      enc_count <= '0;
      mode_err  <= 1'b0;
    end else begin
      if (s1_free) s1_valid <= in_fire;
      if (in_fire) begin
        s1_data <= bus.data_in & low_mask(mode_k(in_mode));
        s1_mode <= in_mode;
        if (in_mode == MODE_RSV) mode_err <= 1'b1;
      end
      // reserved-mode words are dropped here and never occupy S2
      if (s2_free) begin
        s2_valid <= s1_valid && !s1_rsv;
        if (s1_valid && !s1_rsv) s2_code <= s2_in;
      end
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (enc_count != '1) enc_count <= enc_count + CNT_WIDTH'(1);
      end
      if (fifo_rd) rd_ptr <= rd_ptr + PW'(1);
      // head tracks the FIFO front and keeps the last value once empty
      if (fifo_rd && fill > PW'(1))                    head_q <= mem[rd_next];
      else if (fifo_wr && (fifo_empty || fifo_rd))     head_q <= s2_code;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr && !rst) mem[wr_ptr[AW-1:0]] <= s2_code;
  end

endmodule

// File: tb/tb_enc_stream_hamming.sv
module tb_enc_stream_hamming;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] enc_count;
  logic             mode_err;

  int          checks = 0;
  int          errors = 0;
  int          popped = 0;
  int          exp_writes = 0;
  logic [31:0] exp_q [$];

  enc_stream_hamming_if #(.AMBA_WORD(32)) bus ();

  enc_stream_hamming #(.AMBA_WORD(32), .FIFO_DEPTH(4), .CNT_WIDTH(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .enc_count (enc_count),
    .mode_err  (mode_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  // Reference: scatter data into Hamming positions, parity j over positions with bit j set
  function automatic logic [31:0] ref_enc(input logic [1:0] m, input logic [31:0] d);
    int          k, p, di;
    logic [63:0] hv;
    logic [31:0] dk;
    logic [5:0]  par;
    case (m)
      2'd0:    begin k = 4;  p = 4; end
      2'd1:    begin k = 11; p = 5; end
      default: begin k = 26; p = 6; end
    endcase
    dk = d & 32'((64'(1) << k) - 64'(1));
    hv = '0;
    di = 0;
    for (int pos = 3; pos < 64; pos++) begin
      if (di < k && (pos & (pos - 1)) != 0) begin
        hv[6'(pos)] = dk[5'(di)];
        di++;
      end
    end
    par = '0;
    for (int j = 0; j < p - 1; j++)
      for (int q = 1; q < 64; q++)
        if (((q >> j) & 1) == 1) par[3'(j)] = par[3'(j)] ^ hv[6'(q)];
    par[3'(p - 1)] = (($countones(dk) + $countones(par)) % 2) == 1;
    return dk | (32'(par) << k);
  endfunction

  function automatic logic [31:0] nmask(input logic [1:0] m);
    int n;
    n = (m == 2'd0) ? 8 : (m == 2'd1) ? 16 : 32;
    return 32'((64'(1) << n) - 64'(1));
  endfunction

  function automatic void accept(input logic [1:0] m, input logic [31:0] d, input logic [31:0] em);
    if (m != 2'd3) begin
      exp_q.push_back(ref_enc(m, d) ^ (em & nmask(m)));
      exp_writes++;
    end
  endfunction

  // Output scoreboard: every handshake must match the next expected codeword
  always @(negedge clk) begin : mon
    logic [31:0] e;
    #2;
    if (!rst && bus.out_valid && bus.out_ready) begin
      popped++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%h required=none", bus.enc_out);
      end else begin
        e = exp_q.pop_front();
        chk("stream_data", bus.enc_out, e);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send(input logic [1:0] m, input logic [31:0] d, input logic [31:0] em);
    int n;
    bit done;
    n = 0;
    done = 0;
    bus.in_valid = 1'b1;
    bus.codeword_width = m;
    bus.data_in = d;
`ifdef ENC_ERR_INJECT_EN
    bus.err_mask = em;
`endif
    while (!done && n < 100) begin
      #1;
      if (bus.in_ready) begin
        accept(m, d, em);
        done = 1;
      end
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'(n), 32'(0));
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(nm, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    vec_t        vecs [5];
    int          lat, idx, seen, p0, sat;
    logic [1:0]  bp_m [8];
    logic [31:0] bp_d [8];
    logic [1:0]  m;
    logic [31:0] d, em;
    bit          rsv_seen;

    vecs[0] = '{mode: 2'd0, data: 32'h0000_0001, exp: 32'h0000_00B1};
    vecs[1] = '{mode: 2'd0, data: 32'h0000_000F, exp: 32'h0000_00FF};
    vecs[2] = '{mode: 2'd1, data: 32'h0000_07FF, exp: 32'h0000_FFFF};
    vecs[3] = '{mode: 2'd2, data: 32'h0000_0001, exp: 32'h8C00_0001};
    vecs[4] = '{mode: 2'd2, data: 32'h0000_0000, exp: 32'h0000_0000};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_in = '0;
    bus.codeword_width = 2'd0;
    bus.out_ready = 1'b1;
`ifdef ENC_ERR_INJECT_EN
    bus.err_mask = '0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_enc_out", bus.enc_out, 32'(0));
    chk("rst_enc_count", 32'(enc_count), 32'(0));
    chk("rst_mode_err", 32'(mode_err), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'(1));
    @(negedge clk);

    // Table vectors: latency, value and count per word
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].mode, vecs[i].data, 32'(0));
      wait_valid(lat);
      chk("vec_latency", 32'(lat), 32'(3));
      chk("vec_data", bus.enc_out, vecs[i].exp);
      @(negedge clk);
      chk("vec_count", 32'(enc_count), 32'(i + 1));
    end

    // Reserved mode: dropped, sticky error, count unchanged
    send(2'd3, 32'h5, 32'(0));
    repeat (5) @(negedge clk);
    chk("rsv_no_out", 32'(bus.out_valid), 32'(0));
    chk("rsv_mode_err", 32'(mode_err), 32'(1));
    chk("rsv_count", 32'(enc_count), 32'(5));
    send(2'd0, 32'h6, 32'(0));
    wait_valid(lat);
    chk("post_rsv_data", bus.enc_out, 32'h0000_0036);
    @(negedge clk);
    chk("mode_err_sticky", 32'(mode_err), 32'(1));

    // Back-to-back 8/32/16 without bubbles
    send(2'd0, 32'h3, 32'(0));
    send(2'd2, 32'h02AA_AAAA, 32'(0));
    send(2'd1, 32'h555, 32'(0));
    wait_valid(lat);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_valid", 32'(bus.out_valid), 32'(1));
      @(negedge clk);
    end
    drain("b2b_drained");

    // Backpressure: consumer stalled for 10 cycles with 8 words offered
    for (int i = 0; i < 8; i++) begin
      bp_m[i] = 2'($urandom_range(0, 2));
      bp_d[i] = $urandom;
    end
    bus.out_ready = 1'b0;
    p0 = popped;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 8) begin
        bus.in_valid = 1'b1;
        bus.codeword_width = bp_m[idx];
        bus.data_in = bp_d[idx];
        #1;
        if (bus.in_ready) begin
          accept(bp_m[idx], bp_d[idx], 32'(0));
          idx++;
        end
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    chk("bp_accepted", 32'(idx), 32'(6));
    chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
    chk("bp_out_valid", 32'(bus.out_valid), 32'(1));
    @(negedge clk);
    bus.out_ready = 1'b1;
    while (idx < 8) begin
      send(bp_m[idx], bp_d[idx], 32'(0));
      idx++;
    end
    drain("bp_drained");
    chk("bp_popped", 32'(popped - p0), 32'(8));

    // Reset with three words in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(2'($urandom_range(0, 2)), $urandom, 32'(0));
    rst = 1'b1;
    exp_q.delete();
    exp_writes = 0;
    @(negedge clk);
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("midrst_in_ready", 32'(bus.in_ready), 32'(0));
    chk("midrst_enc_out", bus.enc_out, 32'(0));
    chk("midrst_count", 32'(enc_count), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("midrst_no_stale", 32'(seen), 32'(0));
    chk("midrst_mode_err", 32'(mode_err), 32'(0));

`ifdef ENC_ERR_INJECT_EN
    send(2'd0, 32'h1, 32'h01);
    wait_valid(lat);
    chk("inject_b0", bus.enc_out, 32'h0000_00B0);
    @(negedge clk);
    send(2'd0, 32'h1, 32'h100);
    wait_valid(lat);
    chk("inject_above_n", bus.enc_out, 32'h0000_00B1);
    drain("inject_drained");
`endif

    // Randomized traffic with random backpressure against the reference model
    rsv_seen = 0;
    for (int it = 0; it < 400; it++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      m = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      d = $urandom;
`ifdef ENC_ERR_INJECT_EN
      em = ($urandom_range(0, 3) == 0) ? $urandom : 32'(0);
      bus.err_mask = em;
`else
      em = 32'(0);
`endif
      bus.codeword_width = m;
      bus.data_in = d;
      #1;
      if (bus.in_valid && bus.in_ready) begin
        accept(m, d, em);
        if (m == 2'd3) rsv_seen = 1;
      end
      @(negedge clk);
    end
    drain("rand_drained");
    sat = (exp_writes > CNT_MAX) ? CNT_MAX : exp_writes;
    chk("rand_count_sat", 32'(enc_count), 32'(sat));
    chk("rand_mode_err", 32'(mode_err), 32'(rsv_seen));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
